// File: rtl/hazard_detection_unit_pkg.sv
`default_nettype none
// ==========================================================================
// hazard_pkg : shared types for the pipeline hazard controller  | rev 1.0
// ==========================================================================
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_e;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_bubble: 1'b1};
  localparam hz_ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};
  localparam hz_ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
  localparam hz_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};

endpackage
`default_nettype wire

// File: rtl/hazard_detection_unit_if.sv
`default_nettype none
// ==========================================================================
// hazard_detection_unit_if : pipeline <-> hazard controller signals | rev 1.0
// ==========================================================================
interface hazard_detection_unit_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   in_IdEx_MemRead;
  logic [4:0]             in_IdEx_RegisterRt;
  logic                   in_IdEx_MulDiv_Start;
  logic [4:0]             in_IfId_RegisterRs;
  logic [4:0]             in_IfId_RegisterRt;
  logic                   in_IfId_UsesRt;
  logic                   in_IfId_HiLoRead;
  logic                   in_IfId_MulDiv;
  logic                   in_Branch_Taken;
  logic                   out_PC_Write;
  logic                   out_IfId_Write;
  logic                   out_IfId_Flush;
  logic                   out_IdEx_Bubble;
  logic                   out_MulDiv_Busy;
  logic                   out_HiLo_Done;
  logic [STALL_CNT_W-1:0] out_StallCount;

  // Pipeline side drives the status inputs and consumes the enables.
  modport master (
    output in_IdEx_MemRead, in_IdEx_RegisterRt, in_IdEx_MulDiv_Start,
           in_IfId_RegisterRs, in_IfId_RegisterRt, in_IfId_UsesRt,
           in_IfId_HiLoRead, in_IfId_MulDiv, in_Branch_Taken,
    input  out_PC_Write, out_IfId_Write, out_IfId_Flush, out_IdEx_Bubble,
           out_MulDiv_Busy, out_HiLo_Done, out_StallCount
  );

  modport slave (
    input  in_IdEx_MemRead, in_IdEx_RegisterRt, in_IdEx_MulDiv_Start,
           in_IfId_RegisterRs, in_IfId_RegisterRt, in_IfId_UsesRt,
           in_IfId_HiLoRead, in_IfId_MulDiv, in_Branch_Taken,
    output out_PC_Write, out_IfId_Write, out_IfId_Flush, out_IdEx_Bubble,
           out_MulDiv_Busy, out_HiLo_Done, out_StallCount
  );
endinterface
`default_nettype wire

// File: rtl/hazard_detection_unit_muldiv_busy_timer.sv
`default_nettype none
// ==========================================================================
// muldiv_busy_timer : mult/div occupancy countdown + HI/LO done pulse | rev 1.0
// ==========================================================================
module muldiv_busy_timer
  import hazard_pkg::*;
#(
  parameter int MULDIV_LATENCY = 4
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic start_i,
  output logic      busy_o,
  output logic      done_o
);

  localparam logic [3:0] LOAD_VAL = 4'(MULDIV_LATENCY - 1);

  hz_state_e  state_q;
  logic [3:0] cnt_q;
  logic       done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (start_i) begin
            cnt_q   <= LOAD_VAL;
            state_q <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          // A start seen while busy is deliberately not a reload.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RUN;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign busy_o = (state_q == MD_BUSY) & ~reset;
  assign done_o = done_q & ~reset;

endmodule
`default_nettype wire

// File: rtl/hazard_detection_unit.sv
`default_nettype none
// ==========================================================================
// hazard_detection_unit : load-use / mult-div / branch stall+flush control | rev 1.0
// ==========================================================================
module hazard_detection_unit
  import hazard_pkg::*;
#(
  parameter int MULDIV_LATENCY = 4,
  parameter int STALL_CNT_W    = 16
) (
  input wire logic               clk,
  input wire logic               reset,
  hazard_detection_unit_if.slave hz
);

  logic                   md_busy;
  logic                   md_done;
  logic                   load_use_hit;
  logic                   muldiv_hit;
  logic                   stall;
  hz_ctrl_t               ctrl;
  logic [STALL_CNT_W-1:0] count_q;
  logic [STALL_CNT_W-1:0] count_d;

  muldiv_busy_timer #(
    .MULDIV_LATENCY(MULDIV_LATENCY)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start_i(hz.in_IdEx_MulDiv_Start),
    .busy_o (md_busy),
    .done_o (md_done)
  );

  assign load_use_hit = hz.in_IdEx_MemRead
                      & (hz.in_IdEx_RegisterRt != ZERO_REG)
                      & ((hz.in_IdEx_RegisterRt == hz.in_IfId_RegisterRs)
                        | (hz.in_IfId_UsesRt & (hz.in_IdEx_RegisterRt == hz.in_IfId_RegisterRt)));

  assign muldiv_hit = md_busy & (hz.in_IfId_HiLoRead | hz.in_IfId_MulDiv);
  assign stall      = load_use_hit | muldiv_hit;

  // Taken branch wins over a stall: the stalled instruction is being squashed anyway.
  always_comb begin
    ctrl = CTRL_RUN;
    if (reset)                   ctrl = CTRL_RESET;
    else if (hz.in_Branch_Taken) ctrl = CTRL_BRANCH;
    else if (stall)              ctrl = CTRL_STALL;
  end

  always_comb begin
    count_d = count_q;
    if (stall && !hz.in_Branch_Taken && !(&count_q))
      count_d = count_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign hz.out_PC_Write    = ctrl.pc_write;
  assign hz.out_IfId_Write  = ctrl.ifid_write;
  assign hz.out_IfId_Flush  = ctrl.ifid_flush;
  assign hz.out_IdEx_Bubble = ctrl.idex_bubble;
  assign hz.out_MulDiv_Busy = md_busy;
  assign hz.out_HiLo_Done   = md_done;
  assign hz.out_StallCount  = reset ? '0 : count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_detection_unit.sv
`default_nettype none
// ==========================================================================
// tb_hazard_detection_unit : directed + randomized bench with cycle model | rev 1.0
// ==========================================================================
module tb_hazard_detection_unit;

  localparam int LAT = 4;
  localparam int CW  = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_detection_unit_if #(.STALL_CNT_W(CW)) hz ();

  hazard_detection_unit #(
    .MULDIV_LATENCY(LAT),
    .STALL_CNT_W   (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a mult/div started in cycle c owns the unit until cycle c+LAT, where HI/LO is ready.
  bit model_on = 1'b0;
  int cyc      = 0;
  int done_cyc = -1;
  int m_cnt    = 0;
  bit e_busy, e_done, e_lu, e_md, e_stall;
  bit e_pcw, e_ifw, e_fl, e_bub;

  always @(negedge clk) begin
    if (model_on) begin
      e_busy  = !reset && (done_cyc >= 0) && (cyc < done_cyc);
      e_done  = !reset && (cyc == done_cyc);
      e_lu    = hz.in_IdEx_MemRead && (hz.in_IdEx_RegisterRt != 0) &&
                ((hz.in_IdEx_RegisterRt == hz.in_IfId_RegisterRs) ||
                 (hz.in_IfId_UsesRt && (hz.in_IdEx_RegisterRt == hz.in_IfId_RegisterRt)));
      e_md    = e_busy && (hz.in_IfId_HiLoRead || hz.in_IfId_MulDiv);
      e_stall = e_lu || e_md;
      if (reset)                   {e_pcw, e_ifw, e_fl, e_bub} = 4'b0011;
      else if (hz.in_Branch_Taken) {e_pcw, e_ifw, e_fl, e_bub} = 4'b1111;
      else if (e_stall)            {e_pcw, e_ifw, e_fl, e_bub} = 4'b0001;
      else                         {e_pcw, e_ifw, e_fl, e_bub} = 4'b1100;

      chk("pc_write",   32'(hz.out_PC_Write),    32'(e_pcw));
      chk("ifid_write", 32'(hz.out_IfId_Write),  32'(e_ifw));
      chk("ifid_flush", 32'(hz.out_IfId_Flush),  32'(e_fl));
      chk("idex_bubble",32'(hz.out_IdEx_Bubble), 32'(e_bub));
      chk("muldiv_busy",32'(hz.out_MulDiv_Busy), 32'(e_busy));
      chk("hilo_done",  32'(hz.out_HiLo_Done),   32'(e_done));
      chk("stall_count",32'(hz.out_StallCount),  reset ? 32'd0 : 32'(m_cnt));

      if (reset) begin
        m_cnt    = 0;
        done_cyc = -1;
      end else begin
        if (e_stall && !hz.in_Branch_Taken && m_cnt < CNT_MAX) m_cnt++;
        if (hz.in_IdEx_MulDiv_Start && !e_busy) done_cyc = cyc + LAT;
      end
      cyc++;
    end
  end

  task automatic clr_inputs();
    hz.in_IdEx_MemRead      = 1'b0;
    hz.in_IdEx_RegisterRt   = 5'd0;
    hz.in_IdEx_MulDiv_Start = 1'b0;
    hz.in_IfId_RegisterRs   = 5'd0;
    hz.in_IfId_RegisterRt   = 5'd0;
    hz.in_IfId_UsesRt       = 1'b0;
    hz.in_IfId_HiLoRead     = 1'b0;
    hz.in_IfId_MulDiv       = 1'b0;
    hz.in_Branch_Taken      = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic set_load(input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] idrt, input logic uses);
    hz.in_IdEx_MemRead    = 1'b1;
    hz.in_IdEx_RegisterRt = rt;
    hz.in_IfId_RegisterRs = rs;
    hz.in_IfId_RegisterRt = idrt;
    hz.in_IfId_UsesRt     = uses;
  endtask

  initial begin
    clr_inputs();
    reset = 1'b1;
    nxt();
    model_on = 1'b1;
    mid();
    chk("rst_pcw",   32'(hz.out_PC_Write),    0);
    chk("rst_flush", 32'(hz.out_IfId_Flush),  1);
    chk("rst_bub",   32'(hz.out_IdEx_Bubble), 1);
    chk("rst_cnt",   32'(hz.out_StallCount),  0);
    nxt();
    reset = 1'b0;

    // Load to $8, ID reads Rs=$8: one stall cycle.
    set_load(5'd8, 5'd8, 5'd1, 1'b0);
    mid();
    chk("lu_pcw", 32'(hz.out_PC_Write),    0);
    chk("lu_bub", 32'(hz.out_IdEx_Bubble), 1);
    nxt();
    clr_inputs();
    mid();
    chk("lu_cnt",     32'(hz.out_StallCount), 1);
    chk("lu_release", 32'(hz.out_PC_Write),   1);
    nxt();

    set_load(5'd0, 5'd0, 5'd0, 1'b1);
    mid();
    chk("zero_reg_pcw", 32'(hz.out_PC_Write), 1);
    nxt();

    set_load(5'd9, 5'd3, 5'd9, 1'b0);
    mid();
    chk("rt_unused_pcw", 32'(hz.out_PC_Write), 1);
    nxt();
    hz.in_IfId_UsesRt = 1'b1;
    mid();
    chk("rt_used_pcw", 32'(hz.out_PC_Write), 0);
    nxt();
    clr_inputs();

    // mult at T, mfhi waits in ID T+1..T+3, released at T+4.
    hz.in_IdEx_MulDiv_Start = 1'b1;
    nxt();
    hz.in_IdEx_MulDiv_Start = 1'b0;
    hz.in_IfId_HiLoRead     = 1'b1;
    for (int i = 1; i < LAT; i++) begin
      mid();
      chk("md_busy",  32'(hz.out_MulDiv_Busy), 1);
      chk("md_stall", 32'(hz.out_PC_Write),    0);
      nxt();
    end
    mid();
    chk("md_done",    32'(hz.out_HiLo_Done),   1);
    chk("md_idle",    32'(hz.out_MulDiv_Busy), 0);
    chk("md_release", 32'(hz.out_PC_Write),    1);
    chk("md_cnt",     32'(hz.out_StallCount),  5);
    nxt();
    clr_inputs();

    // Branch alongside a load-use hit: flush wins, nothing counted.
    set_load(5'd8, 5'd8, 5'd0, 1'b0);
    hz.in_Branch_Taken = 1'b1;
    mid();
    chk("br_flush", 32'(hz.out_IfId_Flush),  1);
    chk("br_bub",   32'(hz.out_IdEx_Bubble), 1);
    chk("br_pcw",   32'(hz.out_PC_Write),    1);
    nxt();
    clr_inputs();
    mid();
    chk("br_cnt", 32'(hz.out_StallCount), 5);
    nxt();

    // Reset in the middle of a countdown.
    hz.in_IdEx_MulDiv_Start = 1'b1;
    nxt();
    hz.in_IdEx_MulDiv_Start = 1'b0;
    nxt();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    mid();
    chk("rstmd_busy", 32'(hz.out_MulDiv_Busy), 0);
    chk("rstmd_cnt",  32'(hz.out_StallCount),  0);
    nxt();
    mid();
    chk("rstmd_nodone", 32'(hz.out_HiLo_Done), 0);
    nxt();

    for (int i = 0; i < 3000; i++) begin
      reset                   = ($urandom_range(0, 99) == 0);
      hz.in_IdEx_MemRead      = 1'($urandom_range(0, 1));
      hz.in_IdEx_RegisterRt   = 5'($urandom_range(0, 3));
      hz.in_IfId_RegisterRs   = 5'($urandom_range(0, 3));
      hz.in_IfId_RegisterRt   = 5'($urandom_range(0, 3));
      hz.in_IfId_UsesRt       = 1'($urandom_range(0, 1));
      hz.in_IfId_HiLoRead     = ($urandom_range(0, 2) == 0);
      hz.in_IfId_MulDiv       = ($urandom_range(0, 7) == 0);
      hz.in_IdEx_MulDiv_Start = ($urandom_range(0, 5) == 0);
      hz.in_Branch_Taken      = ($urandom_range(0, 7) == 0);
      nxt();
    end

    // Saturation: hold a load-use hit well past 2^16 cycles.
    clr_inputs();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    set_load(5'd8, 5'd8, 5'd0, 1'b0);
    for (int i = 0; i < CNT_MAX + 4; i++) nxt();
    mid();
    chk("sat_cnt", 32'(hz.out_StallCount), 32'hFFFF);
    nxt();
    clr_inputs();
    nxt();

    model_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
